// File: rtl/fpu_mul_pkg.sv
// Shared types and widths for the FPU_MUL mantissa datapath.
// Imported by the iterative multiplier and its rounding stage.
package fpu_mul_pkg;

  localparam int MAN_W   = 24;
  localparam int RADIX_W = 4;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RHA = 2'b10
  } round_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    NORM = 2'b10,
    DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/mul_man_round.sv
// Normalise a 2N-bit mantissa product, derive guard/sticky and round.
// Purely combinational so a pipelined multiplier can reuse it.
module mul_man_round
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_DATA = MAN_W
) (
  input  logic [2*SIZE_DATA-1:0] prod,
  input  logic [1:0]             mode,
  output logic [SIZE_DATA-1:0]   mant,
  output logic                   over,
  output logic                   carry,
  output logic                   inexact
);

  localparam int N = SIZE_DATA;

  logic [N-1:0] m;
  logic         g;
  logic         s;
  logic         inc;
  logic [N:0]   sum;

  always_comb begin
    over = prod[2*N-1];
    if (over) begin
      m = prod[2*N-1:N];
      g = prod[N-1];
      s = |prod[N-2:0];
    end else begin
      m = prod[2*N-2:N-1];
      g = prod[N-2];
      s = |prod[N-3:0];
    end
  end

  // Encoding 2'b11 has no enum member and falls back to RNE.
  always_comb begin
    unique case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RHA:  inc = g;
      default: inc = g & (s | m[0]);
    endcase
  end

  always_comb begin
    sum     = {1'b0, m} + {{N{1'b0}}, inc};
    carry   = sum[N];
    mant    = carry ? {1'b1, {(N-1){1'b0}}} : sum[N-1:0];
    inexact = g | s;
  end

endmodule

// File: rtl/mul_man_iter.sv
// Iterative radix-2^RADIX_BITS mantissa multiplier with
// normalisation, selectable rounding and valid/ready handshakes.
module mul_man_iter
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_DATA  = MAN_W,
  parameter int RADIX_BITS = RADIX_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic [1:0]           i_round_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data_mul,
  output logic                 o_over_flag,
  output logic                 o_round_carry,
  output logic                 o_inexact
);

  localparam int N    = SIZE_DATA;
  localparam int R    = RADIX_BITS;
  localparam int ITER = N / R;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  if (N % R != 0) begin : g_bad_radix
    $error("RADIX_BITS must divide SIZE_DATA");
  end

  mul_state_e     state;
  logic [2*N-1:0] a_sh;
  logic [N-1:0]   b_sh;
  logic [1:0]     mode_q;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] pp;

  logic [N-1:0]   r_mant;
  logic           r_over;
  logic           r_carry;
  logic           r_inexact;

  // Multiplicand is pre-shifted so each digit product lands in place.
  always_comb pp = a_sh * {{(2*N-R){1'b0}}, b_sh[R-1:0]};

  mul_man_round #(.SIZE_DATA(N)) u_round (
    .prod    (acc),
    .mode    (mode_q),
    .mant    (r_mant),
    .over    (r_over),
    .carry   (r_carry),
    .inexact (r_inexact)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      mode_q        <= '0;
      acc           <= '0;
      cnt           <= '0;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_data_mul    <= '0;
      o_over_flag   <= 1'b0;
      o_round_carry <= 1'b0;
      o_inexact     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh    <= {{N{1'b0}}, i_data_a};
            b_sh    <= i_data_b;
            mode_q  <= i_round_mode;
            acc     <= '0;
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          acc  <= acc + pp;
          a_sh <= a_sh << R;
          b_sh <= b_sh >> R;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER-1)) state <= NORM;
        end
        NORM: begin
          o_data_mul    <= r_mant;
          o_over_flag   <= r_over;
          o_round_carry <= r_carry;
          o_inexact     <= r_inexact;
          o_valid       <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
